regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file: successor to the single-channel decode-stage register access block. Provides NUM_RD synchronous read ports with write-through bypass from NUM_WR write ports, replacing the external forwarding-conflict flags. An optional hardwired-zero r0 and a pending-write scoreboard let decode detect RAW hazards without a separate unit. Sits between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_W, 32: register width.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2: read ports, at least 1.
- NUM_WR, 1: write ports, at least 1; higher port index has priority.
- ZERO_REG, 0: 1 = r0 always reads 0, ignores writes and reservations; 0 = r0 writable (SimpleRISC mode).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data, packed the same way.
- rd_busy  out  NUM_RD  registered: register read on port i still has a pending write.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- rsv_en  in  1  mark rsv_addr as having a pending write (decode issues a writing instruction).
- rsv_addr  in  ADDR_W  destination being reserved.
- busy_vec  out  DEPTH  scoreboard, bit a = register a pending.

## Operation
- Storage: DEPTH x DATA_W registers. On async rst all entries, rd_data, rd_busy and busy_vec are cleared to 0. Deasserting rst starts normal operation at the next rising edge.
- Write: on each edge, for each address, the highest-index port j with wr_en[j] and a matching wr_addr stores its wr_data. With ZERO_REG=1, writes to address 0 are dropped.
- Read port i, rd_en[i]=1: at the edge, rd_data[i] gets the bypassed value.
  - Bypassed value = wr_data of the highest-priority write port writing rd_addr[i] in this cycle, if any.
  - Otherwise it is the stored value.
  - With ZERO_REG=1 and rd_addr[i]=0 the value is 0.
- Read port i, rd_en[i]=0: rd_data[i] and rd_busy[i] hold.
- Scoreboard, per address a, evaluated each edge:
  - Next busy[a] = (rsv_en && rsv_addr==a) || (busy[a] && no write to a this cycle).
  - If a reservation and a write hit a in the same cycle, the reservation wins and the bit stays 1: the newer instruction owns it.
  - With ZERO_REG=1, busy[0] is constant 0.
- rd_busy[i] is loaded together with rd_data[i]. It equals busy[rd_addr[i]] with this cycle's writes applied as clears and this cycle's reservation ignored. So a bypassed read is never flagged busy.
- Reads never modify state; any mix of ports may read the same address.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N.
- Write-to-read: a same-cycle write is visible through the bypass at the same edge. Later reads see the stored value.
- Reservation: busy_vec bit set after the edge where rsv_en is sampled. The reservation affects rd_busy from the next read onward.
- Write clear: busy_vec bit cleared after the edge where the write is sampled.
- busy_vec is the registered scoreboard and has no combinational path from any input.
- Reset mid-operation: outputs go to 0 immediately, without waiting for a clock edge. Writes and reservations in flight are lost.
- X-free: all outputs are defined from reset onward.

## Test plan
- Reset, then read r0..r15 on both ports -> all rd_data 0, rd_busy 0, busy_vec 0.
- Write r5=0x1234 at edge N; port 0 reads r5 with rd_en at edge N -> rd_data0=0x1234 after N (bypass). Port 1 reads r5 at N+1 -> 0x1234.
- NUM_WR=2: both ports write r3 in one cycle with 0xAA (port 0) and 0xBB (port 1) -> r3 reads 0xBB.
- rsv_en r7 at N -> busy_vec[7]=1; read r7 at N+1 -> rd_busy=1. Write r7=0x55 at N+3 while reading r7 -> rd_data=0x55, rd_busy=0, busy_vec[7]=0.
- Same cycle: rsv r7 and write r7 -> busy_vec[7] stays 1.
- ZERO_REG=1: write r0=0xFFFF plus rsv r0 -> r0 reads 0, busy_vec[0]=0. ZERO_REG=0: the same stimulus gives 0xFFFF.
- Hold rd_en=0 for 3 cycles while r2 changes -> rd_data holds. Assert rst mid-cycle with no clock edge -> outputs 0 immediately.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-through bypass and a
// pending-write scoreboard.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   address width, DEPTH = 2**ADDR_W registers
//   NUM_RD   number of synchronous read ports (>= 1)
//   NUM_WR   number of write ports (>= 1), higher index has priority
//   ZERO_REG 1 = r0 reads 0 and ignores writes/reservations
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   rd_en/rd_addr              per-port read request (packed by port)
//   rd_data/rd_busy            registered read data and pending-write flag
//   wr_en/wr_addr/wr_data      write ports (packed by port)
//   rsv_en/rsv_addr            reserve a destination as pending
//   busy_vec                   registered scoreboard, one bit per register
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [(1<<ADDR_W)-1:0]     busy_vec
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [DEPTH-1:0]         wr_hit;
  logic [DATA_W-1:0]        wr_val [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic [ADDR_W-1:0]        ra;

  // Per-address write resolution: ascending port loop lets the highest
  // enabled port overwrite lower ones.
  always_comb begin
    wr_hit = '0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      wr_val[a] = '0;
    end
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (wr_en[j]) begin
        wr_hit[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
        wr_val[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
      end
    end
    if (ZERO_REG != 0) begin
      wr_hit[0] = 1'b0;
      wr_val[0] = '0;
    end
  end

  // Reservation takes precedence over a same-cycle write clear: the newer
  // instruction owns the destination.
  always_comb begin
    busy_d = '0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      busy_d[a] = (rsv_en && (rsv_addr == ADDR_W'(a))) || (busy_q[a] && !wr_hit[a]);
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // Read ports: bypass from this cycle's writes; busy sees write clears but
  // not this cycle's reservation, so a bypassed read is never busy.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      if (rd_en[i]) begin
        ra = rd_addr[i*ADDR_W +: ADDR_W];
        if (wr_hit[ra]) begin
          rd_data_d[i*DATA_W +: DATA_W] = wr_val[ra];
        end else begin
          rd_data_d[i*DATA_W +: DATA_W] = mem_q[ra];
        end
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd_data_d[i*DATA_W +: DATA_W] = '0;
        end
        rd_busy_d[i] = busy_q[ra] && !wr_hit[ra];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        mem_q[a] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        if (wr_hit[a]) begin
          mem_q[a] <= wr_val[a];
        end
      end
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances share one
// stimulus stream: dut0 with r0 writable, dut1 with hardwired-zero r0.
// A behavioural array model tracks registers, scoreboard and read outputs.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  rd_busy0, rd_busy1;
  logic [15:0] busy_vec0, busy_vec1;

  int n_cmp;
  int n_err;

  // Model state, index 0 -> dut0, 1 -> dut1 (zero-register mode)
  logic [31:0] m_mem  [2][16];
  logic        m_busy [2][16];
  logic [31:0] m_rd   [2][2];
  logic        m_rb   [2][2];

  regfile_mp #(
    .DATA_W(32), .ADDR_W(4), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)
  ) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec0)
  );

  regfile_mp #(
    .DATA_W(32), .ADDR_W(4), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_busy(rd_busy1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) begin
        m_mem[k][a]  = '0;
        m_busy[k][a] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        m_rd[k][i] = '0;
        m_rb[k][i] = 1'b0;
      end
    end
  endfunction

  // One clock edge of architectural behaviour, from the current inputs.
  function automatic void model_step();
    logic [3:0]  a;
    logic [31:0] v;
    logic        hit;
    logic        zero;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 1);
      // Reads see the old state plus this cycle's writes
      for (int i = 0; i < 2; i++) begin
        if (rd_en[i]) begin
          a   = rd_addr[i*4 +: 4];
          v   = m_mem[k][a];
          hit = 1'b0;
          if (!(zero && a == 4'd0)) begin
            for (int j = 0; j < 2; j++) begin
              if (wr_en[j] && wr_addr[j*4 +: 4] == a) begin
                v   = wr_data[j*32 +: 32];
                hit = 1'b1;
              end
            end
          end else begin
            v = '0;
          end
          m_rd[k][i] = v;
          m_rb[k][i] = m_busy[k][a] && !hit;
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j]) begin
          a = wr_addr[j*4 +: 4];
          if (!(zero && a == 4'd0)) m_mem[k][a] = wr_data[j*32 +: 32];
          m_busy[k][a] = 1'b0;
        end
      end
      if (rsv_en) m_busy[k][rsv_addr] = 1'b1;
      if (zero) m_busy[k][0] = 1'b0;
    end
  endfunction

  function automatic logic [15:0] model_bv(input int k);
    logic [15:0] bv;
    for (int a = 0; a < 16; a++) bv[a] = m_busy[k][a];
    return bv;
  endfunction

  task automatic compare_all();
    check("dut0 rd_data0", {32'h0, rd_data0[31:0]},  {32'h0, m_rd[0][0]});
    check("dut0 rd_data1", {32'h0, rd_data0[63:32]}, {32'h0, m_rd[0][1]});
    check("dut0 rd_busy",  {62'h0, rd_busy0},        {62'h0, m_rb[0][1], m_rb[0][0]});
    check("dut0 busy_vec", {48'h0, busy_vec0},       {48'h0, model_bv(0)});
    check("dut1 rd_data0", {32'h0, rd_data1[31:0]},  {32'h0, m_rd[1][0]});
    check("dut1 rd_data1", {32'h0, rd_data1[63:32]}, {32'h0, m_rd[1][1]});
    check("dut1 rd_busy",  {62'h0, rd_busy1},        {62'h0, m_rb[1][1], m_rb[1][0]});
    check("dut1 busy_vec", {48'h0, busy_vec1},       {48'h0, model_bv(1)});
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  // Inputs are set away from the edge; model advances, then DUT is sampled #1 after.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    model_reset();
    #3;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Read every register on both ports after reset
    for (int a = 0; a < 16; a++) begin
      idle();
      rd_en = 2'b11;
      rd_addr = {a[3:0], a[3:0]};
      step();
    end

    // Bypass: write r5 and read it on port 0 in the same cycle
    idle();
    wr_en = 2'b01; wr_addr[3:0] = 4'd5; wr_data[31:0] = 32'h1234;
    rd_en = 2'b01; rd_addr[3:0] = 4'd5;
    step();
    check("bypass r5 p0", {32'h0, rd_data0[31:0]}, 64'h1234);
    idle();
    rd_en = 2'b10; rd_addr[7:4] = 4'd5;
    step();
    check("stored r5 p1", {32'h0, rd_data0[63:32]}, 64'h1234);

    // Two write ports on r3: port 1 wins
    idle();
    wr_en = 2'b11; wr_addr = {4'd3, 4'd3}; wr_data = {32'hBB, 32'hAA};
    rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
    step();
    check("dual wr bypass r3", {32'h0, rd_data0[31:0]}, 64'hBB);
    idle();
    rd_en = 2'b10; rd_addr = {4'd3, 4'd0};
    step();
    check("dual wr stored r3", {32'h0, rd_data0[63:32]}, 64'hBB);

    // Reservation of r7, busy read, then clearing write with bypass
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    step();
    check("rsv r7 busy_vec", {48'h0, busy_vec0}, 64'h0080);
    idle();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
    step();
    check("r7 rd_busy", {62'h0, rd_busy0}, 64'h1);
    idle();
    step();
    idle();
    wr_en = 2'b10; wr_addr = {4'd7, 4'd0}; wr_data = {32'h55, 32'h0};
    rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
    step();
    check("r7 wr data", {32'h0, rd_data0[31:0]}, 64'h55);
    check("r7 wr rd_busy", {62'h0, rd_busy0}, 64'h0);
    check("r7 wr busy_vec", {63'h0, busy_vec0[7]}, 64'h0);

    // Reservation and write on r7 in the same cycle: reservation stays
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    wr_en = 2'b01; wr_addr = {4'd0, 4'd7}; wr_data = {32'h0, 32'h66};
    rd_en = 2'b10; rd_addr = {4'd7, 4'd0};
    step();
    check("rsv+wr r7 busy_vec", {63'h0, busy_vec0[7]}, 64'h1);
    check("rsv+wr r7 rd_busy", {63'h0, rd_busy0[1]}, 64'h0);

    // r0: writable in dut0, hardwired zero in dut1
    idle();
    wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFF};
    rsv_en = 1'b1; rsv_addr = 4'd0;
    step();
    idle();
    rd_en = 2'b11; rd_addr = '0;
    step();
    check("r0 zero mode data", {32'h0, rd_data1[31:0]}, 64'h0);
    check("r0 zero mode busy", {63'h0, busy_vec1[0]}, 64'h0);
    check("r0 writable data", {32'h0, rd_data0[31:0]}, 64'hFFFF);
    check("r0 writable busy", {63'h0, busy_vec0[0]}, 64'h1);

    // Hold: read r2 once, then disable reads while r2 changes
    idle();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
    step();
    for (int c = 1; c <= 3; c++) begin
      idle();
      rd_addr = {4'd2, 4'd2};
      wr_en = 2'b01; wr_addr = {4'd0, 4'd2}; wr_data = {32'h0, 32'(c * 32'h111)};
      step();
    end
    check("hold r2 data", {32'h0, rd_data0[31:0]}, 64'h0);
    idle();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
    step();
    check("reread r2", {32'h0, rd_data0[31:0]}, 64'h333);

    // Mixed traffic from fixed arithmetic patterns
    for (int c = 0; c < 40; c++) begin
      idle();
      rd_en    = 2'(c % 4);
      rd_addr  = {4'((c * 5) % 16), 4'((c * 3) % 16)};
      wr_en    = 2'((c / 2) % 4);
      wr_addr  = {4'((c * 7 + 1) % 16), 4'((c * 3 + 2) % 16)};
      wr_data  = {32'(32'hC000 + c), 32'(32'h1000 * c + 7)};
      rsv_en   = (c % 3) == 0;
      rsv_addr = 4'((c * 11) % 16);
      step();
    end

    // Async reset away from any edge: outputs must drop immediately
    idle();
    rd_en = 2'b11; rd_addr = {4'd3, 4'd5};
    rsv_en = 1'b1; rsv_addr = 4'd9;
    step();
    idle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async rst rd_data0", rd_data0, 64'h0);
    check("async rst busy_vec0", {48'h0, busy_vec0}, 64'h0);
    compare_all();
    rst = 1'b0;
    rd_en = 2'b11; rd_addr = {4'd3, 4'd5};
    step();
    check("post rst r5", {32'h0, rd_data0[31:0]}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
